// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_if                                                       |
// | Instruction-memory, decode and redirect signals of the fetch stage.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, op, funct3, funct7,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, op, funct3, funct7,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage                                                          |
// | PC register, single-outstanding imem fetch and decode handshake.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;

  logic [31:0] w_redirect_pc;
  logic        w_unused;

  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused      = &{1'b0, bus.redirect_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
          end else if (bus.imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A redirect orphans the outstanding response; drop it now or later.
          if (bus.redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= bus.imem_rsp_valid ? S_REQ : S_DROP;
          end else if (bus.imem_rsp_valid) begin
            r_instr       <= bus.imem_rsp_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            r_pc          <= w_redirect_pc;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end else if (bus.instr_ready) begin
            r_pc          <= r_pc + 32'd4;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
          if (bus.imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = rst_n && (r_state == S_REQ) && !bus.redirect_valid;
  assign bus.imem_addr      = r_pc;
  assign bus.instr_valid    = r_instr_valid;
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.op             = r_instr[6:0];
  assign bus.funct3         = r_instr[14:12];
  assign bus.funct7         = r_instr[31:25];

endmodule
`default_nettype wire
